// File: rtl/tdm_pkg.sv
// Shared TDM definitions: default frame geometry, slot index type and slot bit-offset helper.
package tdm_pkg;
   localparam int N_SLOTS = 8;
   localparam int SEL_W   = $clog2(N_SLOTS);
   localparam int DATA_W  = 1;

   typedef logic [SEL_W-1:0] slot_idx_t;

   function automatic int slot_to_lsb(input int k, input int data_w = DATA_W);
      return k * data_w;
   endfunction
endpackage

// File: rtl/tdm_slot_counter.sv
// Mod-N_SLOTS slot counter shared by the TDM mux driver and demux.
// load1 beats load0, which beats inc.
module tdm_slot_counter #(
   parameter int N_SLOTS = tdm_pkg::N_SLOTS,
   parameter int SEL_W   = $clog2(N_SLOTS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             load0,
   input  logic             load1,
   output logic [SEL_W-1:0] slot,
   output logic             last
);
   logic [SEL_W-1:0] slot_q, slot_d;

   // N_SLOTS is a power of two, so the natural binary wrap is the modulo.
   always_comb begin
      slot_d = slot_q;
      if (load1)      slot_d = SEL_W'(1);
      else if (load0) slot_d = '0;
      else if (inc)   slot_d = slot_q + SEL_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) slot_q <= '0;
      else     slot_q <= slot_d;
   end

   assign slot = slot_q;
   assign last = (slot_q == SEL_W'(N_SLOTS - 1));
endmodule

// File: rtl/tdm_demux8.sv
// TDM receive demultiplexer: steers serial slot samples into an assembly buffer and
// publishes each completed frame. Optional sync_err output under TDM_DEMUX_SYNC_ERR_EN.
module tdm_demux8
   import tdm_pkg::*;
#(
   parameter int N_SLOTS = tdm_pkg::N_SLOTS,
   parameter int SEL_W   = $clog2(N_SLOTS),
   parameter int DATA_W  = tdm_pkg::DATA_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [DATA_W-1:0]         din,
   input  logic                      din_valid,
   input  logic                      sync,
   output logic [SEL_W-1:0]          slot,
   output logic [N_SLOTS*DATA_W-1:0] dout,
   output logic                      frame_valid
`ifdef TDM_DEMUX_SYNC_ERR_EN
  ,output logic                      sync_err
`endif
);
   localparam int FW = N_SLOTS * DATA_W;

   logic [FW-1:0] buf_q, buf_d;
   logic [FW-1:0] dout_q, dout_d;
   logic          fv_q, fv_d;
   logic          last;

   tdm_slot_counter #(.N_SLOTS(N_SLOTS), .SEL_W(SEL_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (din_valid),
      .load0 (sync),
      .load1 (sync & din_valid),
      .slot  (slot),
      .last  (last)
   );

   // Sync restarts the frame and wins over a completion on the last slot.
   always_comb begin
      buf_d  = buf_q;
      dout_d = dout_q;
      fv_d   = 1'b0;
      if (sync) begin
         buf_d = '0;
         if (din_valid) buf_d[0 +: DATA_W] = din;
      end else if (din_valid) begin
         for (int k = 0; k < N_SLOTS; k++)
            if (slot == SEL_W'(k)) buf_d[slot_to_lsb(k, DATA_W) +: DATA_W] = din;
         if (last) begin
            dout_d = buf_d;
            fv_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_q  <= '0;
         dout_q <= '0;
         fv_q   <= 1'b0;
      end else begin
         buf_q  <= buf_d;
         dout_q <= dout_d;
         fv_q   <= fv_d;
      end
   end

   assign dout        = dout_q;
   assign frame_valid = fv_q;

`ifdef TDM_DEMUX_SYNC_ERR_EN
   // synced_q: the frame currently being assembled was started by a sync.
   logic synced_q, synced_d;
   logic err_q, err_d;

   always_comb begin
      synced_d = synced_q;
      err_d    = 1'b0;
      if (sync) begin
         synced_d = 1'b1;
         err_d    = (slot != '0);
      end else if (din_valid && last) begin
         synced_d = 1'b0;
         err_d    = ~synced_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         synced_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         synced_q <= synced_d;
         err_q    <= err_d;
      end
   end

   assign sync_err = err_q;
`endif
endmodule

// File: tb/tb_tdm_demux8.sv
// Bench for tdm_demux8: frame table, hand-written corner sequences and random traffic
// against a slot-level reference model.
module tb_tdm_demux8;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       din = 1'b0;
   logic       din_valid = 1'b0;
   logic       sync = 1'b0;
   logic [2:0] slot;
   logic [7:0] dout;
   logic       frame_valid;
`ifdef TDM_DEMUX_SYNC_ERR_EN
   logic       sync_err;
`endif

   tdm_demux8 dut (
      .clk         (clk),
      .rst         (rst),
      .din         (din),
      .din_valid   (din_valid),
      .sync        (sync),
      .slot        (slot),
      .dout        (dout),
      .frame_valid (frame_valid)
`ifdef TDM_DEMUX_SYNC_ERR_EN
     ,.sync_err    (sync_err)
`endif
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc_n = 0;
   int fv_cnt = 0;
   int fv_cyc = 0;

   // Reference model: frame as an array of samples plus a write position.
   bit m_buf[8];
   int m_pos;
   int m_dout;
   bit m_fv;
   bit m_started_by_sync;
   bit m_err;

   function automatic int pack_buf();
      int v = 0;
      for (int i = 0; i < 8; i++) if (m_buf[i]) v += (1 << i);
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_buf[i] = 0;
      m_pos = 0; m_dout = 0; m_fv = 0; m_started_by_sync = 0; m_err = 0;
   endtask

   task automatic model_step(input bit s, input bit v, input bit d);
      m_fv = 0; m_err = 0;
      if (s) begin
         m_err = (m_pos != 0);
         m_started_by_sync = 1;
         for (int i = 0; i < 8; i++) m_buf[i] = 0;
         if (v) begin m_buf[0] = d; m_pos = 1; end
         else m_pos = 0;
      end else if (v) begin
         m_buf[m_pos] = d;
         if (m_pos == 7) begin
            m_dout = pack_buf();
            m_fv = 1;
            m_err = !m_started_by_sync;
            m_started_by_sync = 0;
            m_pos = 0;
         end else m_pos++;
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   task automatic check_all();
      chk("slot", int'(slot), m_pos);
      chk("dout", int'(dout), m_dout);
      chk("frame_valid", int'(frame_valid), int'(m_fv));
`ifdef TDM_DEMUX_SYNC_ERR_EN
      chk("sync_err", int'(sync_err), int'(m_err));
`endif
   endtask

   // Called at edge+1; applies inputs for one edge and checks the result.
   task automatic cyc(input bit s, input bit v, input bit d);
      sync = s; din_valid = v; din = d;
      model_step(s, v, d);
      @(posedge clk); #1;
      cyc_n++;
      if (frame_valid === 1'b1) begin fv_cnt++; fv_cyc = cyc_n; end
      check_all();
   endtask

   task automatic send_frame(input logic [7:0] bits, input logic [7:0] gaps, input bit use_sync);
      for (int k = 0; k < 8; k++) begin
         cyc(use_sync && k == 0, 1'b1, bits[k]);
         if (gaps[k] && k != 7) cyc(1'b0, 1'b0, 1'b0);
      end
      cyc(1'b0, 1'b0, 1'b0);
   endtask

   typedef struct {
      logic [7:0] bits;
      logic [7:0] gaps;
      bit         use_sync;
      logic [7:0] exp;
   } frame_vec_t;

   frame_vec_t vecs[12];

   initial begin
      int c0, a5_cyc;
      vecs[0] = '{8'h01, 8'h00, 1'b1, 8'h01};
      for (int i = 0; i < 8; i++) vecs[1+i] = '{8'(1 << i), 8'h00, 1'b1, 8'(1 << i)};
      vecs[9]  = '{8'h6B, 8'h55, 1'b1, 8'h6B};
      vecs[10] = '{8'hA5, 8'h00, 1'b1, 8'hA5};
      vecs[11] = '{8'h3C, 8'h00, 1'b0, 8'h3C};

      model_reset();
      #1 rst = 1'b1;
      #2;
      check_all();
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;

      // Frame table; last two are back-to-back with continuous valid.
      a5_cyc = 0;
      for (int t = 0; t < 12; t++) begin
         c0 = fv_cnt;
         for (int k = 0; k < 8; k++) begin
            cyc(vecs[t].use_sync && k == 0, 1'b1, vecs[t].bits[k]);
            if (vecs[t].gaps[k] && k != 7) begin
               cyc(1'b0, 1'b0, 1'b0);
               chk("slot_hold_gap", int'(slot), (k + 1) % 8);
            end
         end
         chk("tbl_dout", int'(dout), int'(vecs[t].exp));
         chk("tbl_fv_pulse", int'(frame_valid), 1);
         if (t == 10) a5_cyc = fv_cyc;
         if (t == 11) chk("b2b_spacing", fv_cyc - a5_cyc, 8);
         if (t < 10) cyc(1'b0, 1'b0, 1'b0);
         chk("tbl_fv_count", fv_cnt - c0, 1);
      end
      cyc(1'b0, 1'b0, 1'b0);
      chk("fv_drops", int'(frame_valid), 0);

      // Mid-frame sync discards the partial frame.
      c0 = fv_cnt;
      cyc(1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b1);
      cyc(1'b1, 1'b1, 1'b1);
      chk("midsync_slot", int'(slot), 1);
      for (int k = 0; k < 7; k++) cyc(1'b0, 1'b1, 1'b0);
      chk("midsync_dout", int'(dout), 8'h01);
      chk("midsync_fv_count", fv_cnt - c0, 1);

      // Sync without valid on the last slot: no completion.
      c0 = fv_cnt;
      for (int k = 0; k < 7; k++) cyc(k == 0, 1'b1, 1'b1);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("sync_on_last_no_fv", fv_cnt - c0, 0);
      chk("sync_on_last_slot", int'(slot), 0);

      // Async reset mid-frame, observed before any clock edge.
      send_frame(8'hFF, 8'h00, 1'b1);
      for (int k = 0; k < 5; k++) cyc(k == 0, 1'b1, 1'b1);
      chk("pre_reset_slot", int'(slot), 5);
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk("async_rst_dout", int'(dout), 0);
      chk("async_rst_slot", int'(slot), 0);
      chk("async_rst_fv", int'(frame_valid), 0);
      @(posedge clk); #1 rst = 1'b0;
      send_frame(8'h96, 8'h00, 1'b0);
      chk("post_reset_dout", int'(dout), 8'h96);

      // Random traffic against the model.
      cyc(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 600; i++)
         cyc($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, 1'($urandom));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
